// File: rtl/io_dmem_ctrl.sv
// io_dmem_ctrl
//
// Responder for the accelerator memory request protocol. It accepts read and
// write burst requests from an initiator and serves them against a
// single-port, word-addressed DMem with a one-cycle synchronous read. It
// returns read data beats in issue order and one status per write burst.
//
// Handshake semantics (all channels): a transfer ("fire") happens on a rising
// clock edge where valid and ready are both 1. A valid source keeps its
// payload stable until it fires. Ready may depend combinationally on valid.
//
// Optional build macro: IO_DMEM_CTRL_STATS_EN adds the beat counters
// stat_read_beats / stat_write_beats. With it undefined they are absent.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_read_addr/_valid/_ready     read burst start address (word address)
//   req_read_len                    read beats, 0 is treated as 1
//   req_write_addr/_valid/_ready    write burst start address (word address)
//   req_write_len                   write beats, 0 is treated as 1
//   req_write_data/_valid/_ready    write data beats
//   resp_read_data/_valid/_ready    read data beats, issue order
//   resp_write_status/_valid/_ready 1 = every beat in range, 0 = some beat dropped
//   dmem_addr, dmem_din, dmem_we    DMem port
//   dmem_dout                       DMem read data, one cycle after dmem_addr
//   stat_read_beats/_write_beats    beat counters (IO_DMEM_CTRL_STATS_EN only)
//   dbg_state                       current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 WRITE_RESP)

module io_dmem_ctrl #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DMEM_AWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [AWIDTH-1:0]      req_read_addr,
    input  logic                   req_read_addr_valid,
    output logic                   req_read_addr_ready,
    input  logic [31:0]            req_read_len,

    input  logic [AWIDTH-1:0]      req_write_addr,
    input  logic                   req_write_addr_valid,
    output logic                   req_write_addr_ready,
    input  logic [31:0]            req_write_len,

    input  logic [DWIDTH-1:0]      req_write_data,
    input  logic                   req_write_data_valid,
    output logic                   req_write_data_ready,

    output logic [DWIDTH-1:0]      resp_read_data,
    output logic                   resp_read_data_valid,
    input  logic                   resp_read_data_ready,

    output logic                   resp_write_status,
    output logic                   resp_write_status_valid,
    input  logic                   resp_write_status_ready,

    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0]      dmem_din,
    output logic                   dmem_we,
    input  logic [DWIDTH-1:0]      dmem_dout,

`ifdef IO_DMEM_CTRL_STATS_EN
    output logic [31:0]            stat_read_beats,
    output logic [31:0]            stat_write_beats,
`endif
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ       = 2'd1,
        WRITE      = 2'd2,
        WRITE_RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Burst bookkeeping
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       beats_q;
    logic              err_q;
    logic              rr_last_read_q;   // 1 = last grant was a read

    // Read return path: one in-flight DMem read plus a 2-entry response FIFO
    logic              inflight_q;
    logic              inflight_oor_q;
    logic [DWIDTH-1:0] fifo_mem_q [2];
    logic              fifo_wr_ptr_q;
    logic              fifo_rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              grant_read;
    logic              grant_write;
    logic              read_addr_fire;
    logic              write_addr_fire;
    logic              data_fire;
    logic              status_fire;
    logic              issue;
    logic              credit_ok;
    logic [2:0]        occupancy;
    logic              addr_oor;
    logic              last_beat;
    logic              enq;
    logic              deq;
    logic [DWIDTH-1:0] enq_data;

    // Any set bit above the DMem index range means the word is not backed by DMem.
    assign addr_oor  = |addr_q[AWIDTH-1:DMEM_AWIDTH];
    assign last_beat = (beats_q == 32'd1);

    // Round-robin: read wins a tie unless the previous grant was a read.
    assign grant_read  = req_read_addr_valid & (~req_write_addr_valid | ~rr_last_read_q);
    assign grant_write = req_write_addr_valid & ~grant_read;

    // Credit counts buffered beats plus the read already on its way from DMem,
    // so an issued read always has a FIFO slot by the time its data arrives.
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    assign credit_ok = (occupancy < 3'd2);
    assign issue     = (state_q == READ) & credit_ok;

    assign read_addr_fire  = req_read_addr_valid  & req_read_addr_ready;
    assign write_addr_fire = req_write_addr_valid & req_write_addr_ready;
    assign data_fire       = req_write_data_valid & req_write_data_ready;
    assign status_fire     = resp_write_status_valid & resp_write_status_ready;

    assign enq      = inflight_q;
    assign enq_data = inflight_oor_q ? '0 : dmem_dout;
    assign deq      = resp_read_data_valid & resp_read_data_ready;

    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read_addr_fire) begin
                    state_d = READ;
                end else if (write_addr_fire) begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (issue && last_beat) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (data_fire && last_beat) begin
                    state_d = WRITE_RESP;
                end
            end
            WRITE_RESP: begin
                if (status_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_read_addr_ready     = 1'b0;
        req_write_addr_ready    = 1'b0;
        req_write_data_ready    = 1'b0;
        resp_write_status_valid = 1'b0;
        resp_write_status       = 1'b0;
        dmem_addr               = '0;
        dmem_din                = '0;
        dmem_we                 = 1'b0;
        case (state_q)
            IDLE: begin
                req_read_addr_ready  = grant_read;
                req_write_addr_ready = grant_write;
            end
            READ: begin
                if (issue) begin
                    dmem_addr = addr_q[DMEM_AWIDTH-1:0];
                end
            end
            WRITE: begin
                req_write_data_ready = 1'b1;
                if (req_write_data_valid) begin
                    dmem_addr = addr_q[DMEM_AWIDTH-1:0];
                    dmem_din  = req_write_data;
                    dmem_we   = ~addr_oor;
                end
            end
            WRITE_RESP: begin
                resp_write_status_valid = 1'b1;
                resp_write_status       = ~err_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Burst address / length / error tracking and arbitration history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            beats_q        <= '0;
            err_q          <= 1'b0;
            rr_last_read_q <= 1'b0;
        end else if (read_addr_fire) begin
            addr_q         <= req_read_addr;
            beats_q        <= (req_read_len == 32'd0) ? 32'd1 : req_read_len;
            err_q          <= 1'b0;
            rr_last_read_q <= 1'b1;
        end else if (write_addr_fire) begin
            addr_q         <= req_write_addr;
            beats_q        <= (req_write_len == 32'd0) ? 32'd1 : req_write_len;
            err_q          <= 1'b0;
            rr_last_read_q <= 1'b0;
        end else if (issue || data_fire) begin
            addr_q  <= addr_q + AWIDTH'(1);
            beats_q <= beats_q - 32'd1;
            if (data_fire && addr_oor) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            inflight_oor_q <= 1'b0;
        end else begin
            inflight_q     <= issue;
            inflight_oor_q <= issue & addr_oor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_q[i] <= '0;
            end
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (enq) begin
                fifo_mem_q[fifo_wr_ptr_q] <= enq_data;
                fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
            end
            if (deq) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign resp_read_data       = fifo_mem_q[fifo_rd_ptr_q];
    assign resp_read_data_valid = (fifo_cnt_q != 2'd0);

`ifdef IO_DMEM_CTRL_STATS_EN
    // ------------------------------------------------------------------
    // Beat counters, free-running with natural wrap
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_read_beats  <= 32'd0;
            stat_write_beats <= 32'd0;
        end else begin
            if (issue) begin
                stat_read_beats <= stat_read_beats + 32'd1;
            end
            if (data_fire) begin
                stat_write_beats <= stat_write_beats + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_dmem_ctrl.sv
// Directed testbench for io_dmem_ctrl. A behavioural DMem (synchronous read,
// unwritten words read back as 0xA5A50000 | address) sits on the DMem port.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.

module tb_io_dmem_ctrl;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic [31:0] req_read_addr;
    logic        req_read_addr_valid;
    logic        req_read_addr_ready;
    logic [31:0] req_read_len;
    logic [31:0] req_write_addr;
    logic        req_write_addr_valid;
    logic        req_write_addr_ready;
    logic [31:0] req_write_len;
    logic [31:0] req_write_data;
    logic        req_write_data_valid;
    logic        req_write_data_ready;
    logic [31:0] resp_read_data;
    logic        resp_read_data_valid;
    logic        resp_read_data_ready;
    logic        resp_write_status;
    logic        resp_write_status_valid;
    logic        resp_write_status_ready;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic        dmem_we;
    logic [31:0] dmem_dout;
    logic [1:0]  dbg_state;
`ifdef IO_DMEM_CTRL_STATS_EN
    logic [31:0] stat_read_beats;
    logic [31:0] stat_write_beats;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    io_dmem_ctrl #(
        .AWIDTH      (32),
        .DWIDTH      (32),
        .DMEM_AWIDTH (14)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .req_read_addr           (req_read_addr),
        .req_read_addr_valid     (req_read_addr_valid),
        .req_read_addr_ready     (req_read_addr_ready),
        .req_read_len            (req_read_len),
        .req_write_addr          (req_write_addr),
        .req_write_addr_valid    (req_write_addr_valid),
        .req_write_addr_ready    (req_write_addr_ready),
        .req_write_len           (req_write_len),
        .req_write_data          (req_write_data),
        .req_write_data_valid    (req_write_data_valid),
        .req_write_data_ready    (req_write_data_ready),
        .resp_read_data          (resp_read_data),
        .resp_read_data_valid    (resp_read_data_valid),
        .resp_read_data_ready    (resp_read_data_ready),
        .resp_write_status       (resp_write_status),
        .resp_write_status_valid (resp_write_status_valid),
        .resp_write_status_ready (resp_write_status_ready),
        .dmem_addr               (dmem_addr),
        .dmem_din                (dmem_din),
        .dmem_we                 (dmem_we),
        .dmem_dout               (dmem_dout),
`ifdef IO_DMEM_CTRL_STATS_EN
        .stat_read_beats         (stat_read_beats),
        .stat_write_beats        (stat_write_beats),
`endif
        .dbg_state               (dbg_state)
    );

    // ------------------------------------------------------------------
    // DMem model: read-before-write, one-cycle read latency
    // ------------------------------------------------------------------
    logic [31:0] mem [int];

    always @(posedge clk) begin
        logic [31:0] rd;
        int a;
        a  = int'(dmem_addr);
        rd = mem.exists(a) ? mem[a] : (32'hA5A5_0000 | 32'(a));
        if (dmem_we) mem[a] = dmem_din;
        dmem_dout <= rd;
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic drive_idle();
        req_read_addr           = '0;
        req_read_addr_valid     = 1'b0;
        req_read_len            = '0;
        req_write_addr          = '0;
        req_write_addr_valid    = 1'b0;
        req_write_len           = '0;
        req_write_data          = '0;
        req_write_data_valid    = 1'b0;
        resp_read_data_ready    = 1'b1;
        resp_write_status_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (req_read_addr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready: got %b expected 0", req_read_addr_ready); end
        n_cmp++; if (req_write_addr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 0", req_write_addr_ready); end
        n_cmp++; if (req_write_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wd_ready: got %b expected 0", req_write_data_ready); end
        n_cmp++; if (resp_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", resp_read_data_valid); end
        n_cmp++; if (resp_write_status_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ws_valid: got %b expected 0", resp_write_status_valid); end
        n_cmp++; if (resp_read_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", resp_read_data); end
        n_cmp++; if ({dmem_we, dmem_addr, dmem_din} !== 47'h0) begin n_fail++; $display("FAIL reset_dmem: got we=%b addr=%h din=%h expected all 0", dmem_we, dmem_addr, dmem_din); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_single();
        @(negedge clk);
        req_write_addr       = 32'h10;
        req_write_len        = 32'd1;
        req_write_addr_valid = 1'b1;
        #1;
        n_cmp++; if (req_write_addr_ready !== 1'b1) begin n_fail++; $display("FAIL wr1_addr_ready: got %b expected 1", req_write_addr_ready); end
        n_cmp++; if (req_read_addr_ready !== 1'b0) begin n_fail++; $display("FAIL wr1_rd_ready: got %b expected 0", req_read_addr_ready); end
        @(negedge clk);
        req_write_addr_valid = 1'b0;
        req_write_data       = 32'hDEAD_BEEF;
        req_write_data_valid = 1'b1;
        #1;
        n_cmp++; if (req_write_data_ready !== 1'b1) begin n_fail++; $display("FAIL wr1_data_ready: got %b expected 1", req_write_data_ready); end
        n_cmp++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL wr1_we: got %b expected 1", dmem_we); end
        n_cmp++; if (dmem_addr !== 14'h10) begin n_fail++; $display("FAIL wr1_addr: got %h expected 0010", dmem_addr); end
        n_cmp++; if (dmem_din !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr1_din: got %h expected deadbeef", dmem_din); end
        @(negedge clk);
        req_write_data_valid = 1'b0;
        #1;
        n_cmp++; if (resp_write_status_valid !== 1'b1) begin n_fail++; $display("FAIL wr1_status_valid: got %b expected 1", resp_write_status_valid); end
        n_cmp++; if (resp_write_status !== 1'b1) begin n_fail++; $display("FAIL wr1_status: got %b expected 1", resp_write_status); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp_write_status_valid !== 1'b0) begin n_fail++; $display("FAIL wr1_status_drop: got %b expected 0", resp_write_status_valid); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL wr1_idle: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_read_single(input logic [31:0] addr, input logic [31:0] exp_data);
        @(negedge clk);
        resp_read_data_ready = 1'b1;
        req_read_addr        = addr;
        req_read_len         = 32'd1;
        req_read_addr_valid  = 1'b1;
        #1;
        n_cmp++; if (req_read_addr_ready !== 1'b1) begin n_fail++; $display("FAIL rd1_addr_ready: got %b expected 1", req_read_addr_ready); end
        @(negedge clk);
        req_read_addr_valid = 1'b0;
        #1;
        n_cmp++; if (dmem_addr !== addr[13:0]) begin n_fail++; $display("FAIL rd1_dmem_addr: got %h expected %h", dmem_addr, addr[13:0]); end
        n_cmp++; if (resp_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL rd1_early_t1: got %b expected 0", resp_read_data_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL rd1_early_t2: got %b expected 0", resp_read_data_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp_read_data_valid !== 1'b1) begin n_fail++; $display("FAIL rd1_valid_t3: got %b expected 1", resp_read_data_valid); end
        n_cmp++; if (resp_read_data !== exp_data) begin n_fail++; $display("FAIL rd1_data: got %h expected %h", resp_read_data, exp_data); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL rd1_single_beat: got %b expected 0", resp_read_data_valid); end
    endtask

    task automatic test_read_backpressure();
        logic [31:0] exp_q[$];
        logic        pat [4];
        logic        prev_hold;
        logic [31:0] prev_data;
        logic [31:0] exp_v;
        int          issued;
        int          delivered;
        int          max_out;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA5A5_0020 + 32'(i));
        prev_hold = 1'b0;
        prev_data = '0;
        issued    = 0;
        delivered = 0;
        max_out   = 0;
        @(negedge clk);
        resp_read_data_ready = 1'b0;
        req_read_addr        = 32'h20;
        req_read_len         = 32'd4;
        req_read_addr_valid  = 1'b1;
        #1;
        n_cmp++; if (req_read_addr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_addr_ready: got %b expected 1", req_read_addr_ready); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_read_addr_valid  = 1'b0;
            resp_read_data_ready = pat[i % 4];
            #1;
            if (dbg_state == 2'd1 && dmem_addr != 14'h0) issued++;
            if (issued - delivered > max_out) max_out = issued - delivered;
            if (prev_hold) begin
                n_cmp++;
                if (resp_read_data_valid !== 1'b1 || resp_read_data !== prev_data) begin
                    n_fail++; $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=%h", resp_read_data_valid, resp_read_data, prev_data);
                end
            end
            if (resp_read_data_valid && resp_read_data_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_beat: got %h expected no beat", resp_read_data);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (resp_read_data !== exp_v) begin n_fail++; $display("FAIL bp_data: got %h expected %h", resp_read_data, exp_v); end
                end
                delivered++;
            end
            prev_hold = resp_read_data_valid & ~resp_read_data_ready;
            prev_data = resp_read_data;
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_missing: got %0d beats left expected 0", exp_q.size()); end
        n_cmp++; if (issued != 4) begin n_fail++; $display("FAIL bp_issued: got %0d expected 4", issued); end
        n_cmp++; if (max_out > 2) begin n_fail++; $display("FAIL bp_inflight: got %0d expected at most 2", max_out); end
        resp_read_data_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic granted;
        logic got_read;
        logic exp_read;
        pulse_reset();
        resp_read_data_ready    = 1'b1;
        resp_write_status_ready = 1'b1;
        req_read_addr           = 32'h30;
        req_read_len            = 32'd1;
        req_write_addr          = 32'h40;
        req_write_len           = 32'd1;
        req_read_addr_valid     = 1'b1;
        req_write_addr_valid    = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            granted = 1'b0;
            for (int t = 0; t < 20 && !granted; t++) begin
                if (req_read_addr_ready || req_write_addr_ready) granted = 1'b1;
                else begin @(negedge clk); #1; end
            end
            n_cmp++;
            if (!granted) begin
                n_fail++; $display("FAIL rr_timeout: got no grant expected grant %0d", k);
                break;
            end
            n_cmp++; if (req_read_addr_ready && req_write_addr_ready) begin n_fail++; $display("FAIL rr_both_ready: got 11 expected one-hot"); end
            got_read = req_read_addr_ready;
            exp_read = ((k % 2) == 0);
            n_cmp++; if (got_read !== exp_read) begin n_fail++; $display("FAIL rr_order: grant %0d got read=%b expected read=%b", k, got_read, exp_read); end
            @(negedge clk);
            if (k == 3) begin
                req_read_addr_valid  = 1'b0;
                req_write_addr_valid = 1'b0;
            end
            if (!got_read) begin
                req_write_data       = 32'(k);
                req_write_data_valid = 1'b1;
                @(negedge clk);
                req_write_data_valid = 1'b0;
            end
            #1;
        end
        req_read_addr_valid  = 1'b0;
        req_write_addr_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_oob();
        @(negedge clk);
        req_write_addr       = 32'h3FFF;
        req_write_len        = 32'd2;
        req_write_addr_valid = 1'b1;
        #1;
        n_cmp++; if (req_write_addr_ready !== 1'b1) begin n_fail++; $display("FAIL oob_addr_ready: got %b expected 1", req_write_addr_ready); end
        @(negedge clk);
        req_write_addr_valid = 1'b0;
        req_write_data       = 32'h1111_1111;
        req_write_data_valid = 1'b1;
        #1;
        n_cmp++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL oob_we_beat0: got %b expected 1", dmem_we); end
        n_cmp++; if (dmem_addr !== 14'h3FFF) begin n_fail++; $display("FAIL oob_addr_beat0: got %h expected 3fff", dmem_addr); end
        @(negedge clk);
        req_write_data = 32'h2222_2222;
        #1;
        n_cmp++; if (req_write_data_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready_beat1: got %b expected 1", req_write_data_ready); end
        n_cmp++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL oob_we_beat1: got %b expected 0", dmem_we); end
        @(negedge clk);
        req_write_data_valid = 1'b0;
        #1;
        n_cmp++; if (resp_write_status_valid !== 1'b1) begin n_fail++; $display("FAIL oob_status_valid: got %b expected 1", resp_write_status_valid); end
        n_cmp++; if (resp_write_status !== 1'b0) begin n_fail++; $display("FAIL oob_status: got %b expected 0", resp_write_status); end
        @(negedge clk);
        #1;
        n_cmp++; if (resp_write_status_valid !== 1'b0) begin n_fail++; $display("FAIL oob_status_drop: got %b expected 0", resp_write_status_valid); end
    endtask

    task automatic test_reset_mid_burst();
        logic seen;
        @(negedge clk);
        resp_read_data_ready = 1'b0;
        req_read_addr        = 32'h20;
        req_read_len         = 32'd4;
        req_read_addr_valid  = 1'b1;
        #1;
        n_cmp++; if (req_read_addr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_addr_ready: got %b expected 1", req_read_addr_ready); end
        @(negedge clk);
        req_read_addr_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (resp_read_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 1", resp_read_data_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b expected 0", resp_read_data_valid); end
        n_cmp++; if (resp_write_status_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ws_valid: got %b expected 0", resp_write_status_valid); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d expected 0", dbg_state); end
        @(negedge clk);
        rst_n                = 1'b1;
        resp_read_data_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (resp_read_data_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_stale_beat: got a beat expected none"); end
        test_read_single(32'h10, 32'hDEAD_BEEF);
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        drive_idle();
        test_reset();
        test_write_single();
        test_read_single(32'h10, 32'hDEAD_BEEF);
        test_read_backpressure();
        test_round_robin();
        test_write_oob();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
